// File: rtl/arb_rr_n_pkg.sv
`default_nettype none
// ============================================================================
//  Package : arb_pkg
//  Purpose : Shared definitions for the arb_rr_n bus arbiter: FSM state
//            encoding, default hold limit and a one-hot to index helper.
//  Rev     : 1.0  initial release
// ============================================================================
package arb_pkg;

  // Arbiter FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // Default maximum consecutive grant cycles while another master waits.
  localparam int C_MAX_HOLD_DEFAULT = 16;

  // Widest requester vector handled by oh2idx (matches the N_REQ ceiling).
  localparam int C_OH_WIDTH = 16;

  // One-hot to binary index. Bits are OR-combined, so a zero vector maps to 0.
  function automatic logic [3:0] oh2idx(input logic [C_OH_WIDTH-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < C_OH_WIDTH; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_n_pick.sv
`default_nettype none
// ============================================================================
//  Module  : arb_rr_pick
//  Purpose : Combinational masked priority picker. Selects the first
//            eligible request scanning upward from a start pointer (wrapping),
//            or from index 0 when fixed mode is selected.
//  Ports   : i_req      requests
//            i_start    round-robin scan start index
//            i_excl     mask of requests to ignore this pick
//            i_fixed    1 = fixed priority (index 0 highest)
//            o_win_oh   one-hot winner (0 when nothing eligible)
//            o_win_idx  winner index (0 when nothing eligible)
//  Rev     : 1.0  initial release
// ============================================================================
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_start,
  input  logic [N_REQ-1:0] i_excl,
  input  logic             i_fixed,
  output logic [N_REQ-1:0] o_win_oh,
  output logic [IDW-1:0]   o_win_idx
);

  logic [N_REQ-1:0] w_elig;
  logic [IDW-1:0]   w_start;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_oh_rot;

  assign w_elig  = i_req & ~i_excl;
  assign w_start = i_fixed ? '0 : i_start;

  // Rotate right by the start pointer so the scan origin lands on bit 0;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  assign w_rot    = N_REQ'({w_elig, w_elig} >> w_start);
  assign w_oh_rot = w_rot & (~w_rot + N_REQ'(1));

  // Rotate the one-hot winner back to its original position.
  assign o_win_oh  = N_REQ'(({w_oh_rot, w_oh_rot} << w_start) >> N_REQ);
  assign o_win_idx = IDW'(oh2idx(C_OH_WIDTH'(o_win_oh)));

endmodule
`default_nettype wire

// File: rtl/arb_rr_n.sv
`default_nettype none
// ============================================================================
//  Module  : arb_rr_n
//  Purpose : N-requester shared-memory bus arbiter. Round-robin or fixed
//            priority, bounded hold time with preemption, and a mandatory
//            one-cycle turnaround (no grant) between successive owners.
//  Ports   : clk          system clock, rising edge
//            reset        asynchronous active-high reset
//            breq         level request per master
//            grant        one-hot registered grant
//            grant_valid  registered OR of grant
//            grant_id     index of current owner, 0 when no owner
//            preempt      one-cycle pulse when the owner is forcibly removed
//  Rev     : 1.0  initial release
// ============================================================================
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = C_MAX_HOLD_DEFAULT,
  parameter int FIXED_PRIO = 0,
  parameter int IDW        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] breq,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic             preempt
);

  localparam int            HCW          = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] C_HOLD_MAX  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] C_HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic           C_PREEMPT_EN = (MAX_HOLD > 0);
  localparam logic           C_FIXED      = (FIXED_PRIO != 0);
  localparam logic [IDW-1:0] C_LAST_IDX   = IDW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             preempt_q, preempt_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] excl_q, excl_d;

  logic [N_REQ-1:0] w_win_oh;
  logic [IDW-1:0]   w_win_idx;
  logic             w_any_win;
  logic [IDW-1:0]   w_ptr_next;
  logic             w_owner_req;
  logic             w_others;

  // excl_q is only non-zero while in TURN right after a preemption, so it
  // can feed the picker unconditionally.
  arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .i_req     (breq),
    .i_start   (rr_ptr_q),
    .i_excl    (excl_q),
    .i_fixed   (C_FIXED),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  assign w_any_win   = |w_win_oh;
  assign w_ptr_next  = (w_win_idx == C_LAST_IDX) ? '0 : w_win_idx + IDW'(1);
  assign w_owner_req = |(breq & grant_q);
  assign w_others    = |(breq & ~grant_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    excl_d     = excl_q;

    case (state_q)
      IDLE: begin
        if (w_any_win) begin
          grant_d    = w_win_oh;
          grant_id_d = w_win_idx;
          rr_ptr_d   = w_ptr_next;
          hold_cnt_d = '0;
          state_d    = OWN;
        end
      end

      OWN: begin
        if (!w_owner_req) begin
          // Voluntary release takes precedence over a coincident preemption.
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          state_d    = TURN;
        end else if (C_PREEMPT_EN && (hold_cnt_q == C_HOLD_LAST) && w_others) begin
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
          excl_d     = grant_q;
          state_d    = TURN;
        end else if (hold_cnt_q != C_HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      TURN: begin
        // The exclusion applies to this one selection only.
        excl_d = '0;
        if (w_any_win) begin
          grant_d    = w_win_oh;
          grant_id_d = w_win_idx;
          rr_ptr_d   = w_ptr_next;
          hold_cnt_d = '0;
          state_d    = OWN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        hold_cnt_d = '0;
        excl_d     = '0;
      end
    endcase

    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      preempt_q     <= 1'b0;
      hold_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      excl_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      preempt_q     <= preempt_d;
      hold_cnt_q    <= hold_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      excl_q        <= excl_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign preempt     = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_n.sv
`default_nettype none
// ============================================================================
//  Module  : tb_arb_rr_n
//  Purpose : Self-checking bench for arb_rr_n. Three instances cover
//            round-robin with MAX_HOLD=4, fixed priority without preemption,
//            and round-robin with MAX_HOLD=2.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_arb_rr_n;

  typedef struct packed {
    logic [3:0] breq;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] breq_a, breq_b, breq_c;
  logic [3:0] grant_a, grant_b, grant_c;
  logic       gv_a, gv_b, gv_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic       pre_a, pre_b, pre_c;

  int   total;
  int   bad;
  vec_t sb[$];
  vec_t tbl[$];

  arb_rr_n #(.N_REQ(4), .MAX_HOLD(4), .FIXED_PRIO(0), .IDW(2)) u_dut_a (
    .clk(clk), .reset(reset), .breq(breq_a), .grant(grant_a),
    .grant_valid(gv_a), .grant_id(gid_a), .preempt(pre_a)
  );

  arb_rr_n #(.N_REQ(4), .MAX_HOLD(0), .FIXED_PRIO(1), .IDW(2)) u_dut_b (
    .clk(clk), .reset(reset), .breq(breq_b), .grant(grant_b),
    .grant_valid(gv_b), .grant_id(gid_b), .preempt(pre_b)
  );

  arb_rr_n #(.N_REQ(4), .MAX_HOLD(2), .FIXED_PRIO(0), .IDW(2)) u_dut_c (
    .clk(clk), .reset(reset), .breq(breq_c), .grant(grant_c),
    .grant_valid(gv_c), .grant_id(gid_c), .preempt(pre_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs(input int sel);
    case (sel)
      0:       return {grant_a, gv_a, gid_a, pre_a};
      1:       return {grant_b, gv_b, gid_b, pre_b};
      default: return {grant_c, gv_c, gid_c, pre_c};
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: grant/valid/id/pre got %b want %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of requests on the selected instance, queue the expected
  // outputs, then compare them just after the clock edge.
  task automatic cyc(input int sel, input vec_t v, input string nm);
    vec_t e;
    breq_a = (sel == 0) ? v.breq : 4'b0000;
    breq_b = (sel == 1) ? v.breq : 4'b0000;
    breq_c = (sel == 2) ? v.breq : 4'b0000;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp(nm, outs(sel), {e.grant, e.valid, e.id, e.pre});
  endtask

  task automatic run_tbl(input int sel, input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(sel, tbl[i], $sformatf("%s[%0d]", nm, i));
    end
  endtask

  task automatic do_reset();
    breq_a = '0;
    breq_b = '0;
    breq_c = '0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t z;
    total  = 0;
    bad    = 0;
    z      = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    breq_a = '0;
    breq_b = '0;
    breq_c = '0;
    reset  = 1'b1;

    // Reset held for three cycles, then two idle cycles.
    for (int i = 0; i < 3; i++) cyc(0, z, $sformatf("reset_a[%0d]", i));
    cmp("reset_b", outs(1), 8'h00);
    cmp("reset_c", outs(2), 8'h00);
    reset = 1'b0;
    cyc(0, z, "idle_a[0]");
    cyc(0, z, "idle_a[1]");

    // Single requester: four granted cycles, one TURN, then IDLE.
    do_reset();
    tbl = '{
      '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(0, "single");

    // Round-robin rotation 0,1,2,3,0 with a gap cycle between owners.
    do_reset();
    tbl = '{
      '{4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b1011, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0},
      '{4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0},
      '{4'b0111, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(0, "rr");

    // Preemption at MAX_HOLD=4: owner 0 for exactly 4 cycles, pulse, then 2.
    do_reset();
    tbl = '{
      '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0101, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0101, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0101, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0101, 4'b0000, 1'b0, 2'd0, 1'b1},
      '{4'b0101, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(0, "preempt");

    // Preempted master alone after TURN: falls to IDLE, then granted.
    do_reset();
    tbl = '{
      '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0011, 4'b0000, 1'b0, 2'd0, 1'b1},
      '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(0, "excl_only");

    // Fixed priority without preemption: 0 beats 3 after 2 releases.
    do_reset();
    tbl = '{
      '{4'b1100, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b1101, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b1101, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1001, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(1, "fixed");

    // MAX_HOLD=2: release on the preempt-eligible edge gives no pulse;
    // a later genuine preemption does pulse.
    do_reset();
    tbl = '{
      '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0011, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0011, 4'b0000, 1'b0, 2'd0, 1'b1},
      '{4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(2, "rel_vs_pre");

    // Reset mid-grant clears grant before the next edge; rr_ptr restarts at 0.
    do_reset();
    tbl = '{
      '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0},
      '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0}
    };
    run_tbl(0, "pre_reset");
    breq_a = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    cmp("midreset_async", outs(0), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tbl = '{
      '{4'b1010, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0}
    };
    run_tbl(0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
